// File: rtl/ff_k4_pkg.sv
// Shared GF(2^4) definitions (x^4+x+1) for the field multiplier and divider.
// Also holds the divider FSM state type and the field helper functions.
package ff_k4_pkg;

    localparam int          GF4_WIDTH   = 4;
    localparam logic [4:0]  GF4_POLY    = 5'b10011;
    localparam int          GF4_EXP_INV = 14;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SQR1 = 3'd1,
        ST_MUL1 = 3'd2,
        ST_SQR2 = 3'd3,
        ST_MUL2 = 3'd4,
        ST_SQR3 = 3'd5,
        ST_MUL3 = 3'd6,
        ST_HOLD = 3'd7
    } div_state_e;

    // Multiply by x and reduce by the field polynomial.
    function automatic logic [GF4_WIDTH-1:0] gf4_xtime(input logic [GF4_WIDTH-1:0] v);
        logic [GF4_WIDTH-1:0] shifted;
        shifted = {v[GF4_WIDTH-2:0], 1'b0};
        if (v[GF4_WIDTH-1]) begin
            shifted = shifted ^ GF4_POLY[GF4_WIDTH-1:0];
        end
        return shifted;
    endfunction

    function automatic logic [GF4_WIDTH-1:0] gf4_times_xn(input logic [GF4_WIDTH-1:0] v,
                                                         input int n);
        logic [GF4_WIDTH-1:0] acc;
        acc = v;
        for (int k = 0; k < GF4_WIDTH - 1; k++) begin
            if (k < n) begin
                acc = gf4_xtime(acc);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/FFMul_K4_Q2.sv
// Combinational GF(2^4) multiplier: p = a * b mod x^4+x+1.
// Each set bit of b contributes a * x^i, already reduced into the field.
module FFMul_K4_Q2
    import ff_k4_pkg::*;
(
    input  logic [GF4_WIDTH-1:0] a_i,
    input  logic [GF4_WIDTH-1:0] b_i,
    output logic [GF4_WIDTH-1:0] p_o
);

    logic [GF4_WIDTH-1:0] partial [GF4_WIDTH];

    generate
        for (genvar gi = 0; gi < GF4_WIDTH; gi++) begin : g_partial
            assign partial[gi] = b_i[gi] ? gf4_times_xn(a_i, gi) : '0;
        end
    endgenerate

    always_comb begin
        p_o = '0;
        for (int i = 0; i < GF4_WIDTH; i++) begin
            p_o = p_o ^ partial[i];
        end
    end

endmodule

// File: rtl/ff_div_k4_q2.sv
// Sequential GF(2^4) divider: quotient = dividend * divisor^14 using one shared
// multiplier over a fixed 6-step square/multiply schedule, then a result hold.
module ff_div_k4_q2
    import ff_k4_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [GF4_WIDTH-1:0] dividend,
    input  logic [GF4_WIDTH-1:0] divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [GF4_WIDTH-1:0] quotient,
    output logic                 div_by_zero
);

    div_state_e           state_q, state_d;
    logic [GF4_WIDTH-1:0] r_q, r_d;
    logic [GF4_WIDTH-1:0] s_q, s_d;
    logic                 zero_q, zero_d;
    logic [GF4_WIDTH-1:0] quot_q, quot_d;
    logic                 dz_q, dz_d;
    logic                 out_valid_q, out_valid_d;

    logic [GF4_WIDTH-1:0] mul_a, mul_b, mul_p;

    FFMul_K4_Q2 u_mul (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (mul_p)
    );

    // Operand mux depends on state only: squaring steps use (s, s), multiply steps (r, s).
    always_comb begin
        mul_b = s_q;
        unique case (state_q)
            ST_MUL1, ST_MUL2, ST_MUL3: mul_a = r_q;
            default:                   mul_a = s_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        s_d         = s_q;
        zero_d      = zero_q;
        quot_d      = quot_q;
        dz_d        = dz_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    r_d     = dividend;
                    s_d     = divisor;
                    zero_d  = (divisor == '0);
                    dz_d    = 1'b0;
                    state_d = ST_SQR1;
                end
            end
            ST_SQR1: begin
                s_d     = mul_p;
                state_d = ST_MUL1;
            end
            ST_MUL1: begin
                r_d     = mul_p;
                state_d = ST_SQR2;
            end
            ST_SQR2: begin
                s_d     = mul_p;
                state_d = ST_MUL2;
            end
            ST_MUL2: begin
                r_d     = mul_p;
                state_d = ST_SQR3;
            end
            ST_SQR3: begin
                s_d     = mul_p;
                state_d = ST_MUL3;
            end
            ST_MUL3: begin
                // r * s here is a * b^14, the final quotient.
                r_d         = mul_p;
                quot_d      = mul_p;
                dz_d        = zero_q;
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            r_q         <= '0;
            s_q         <= '0;
            zero_q      <= 1'b0;
            quot_q      <= '0;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            s_q         <= s_d;
            zero_q      <= zero_d;
            quot_q      <= quot_d;
            dz_q        <= dz_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = out_valid_q;
    assign quotient    = quot_q;
    assign div_by_zero = dz_q;

endmodule

// File: doc/ff_div_k4_q2.md
Name: ff_div_k4_q2

Overview:
- Sequential GF(2^4) divider: quotient = dividend * divisor^-1 in the same field as FFMul_K4_Q2 (polynomial x^4+x+1, 4'b0010 = x).
- Computes divisor^-1 as divisor^14 by iterated square-and-multiply, time-sharing one FFMul_K4_Q2 instance.
- Inverse direction of the existing multiplier; feeds the composite-field S-box inversion path.
- Constant latency regardless of operands, including divide-by-zero.

Parameters:
- none (field width 4 and polynomial fixed in shared package)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands presented
- in_ready  out  1  block can accept operands
- dividend  in  4  field element a
- divisor  in  4  field element b
- out_valid  out  1  result presented
- out_ready  in  1  consumer accepts result
- quotient  out  4  a * b^-1
- div_by_zero  out  1  set with result when b == 0

Behaviour:
- Reset (async, active-high): state IDLE; in_ready=1; out_valid=0; quotient=0; div_by_zero=0; internal r, s registers = 0. Reset mid-operation aborts the computation; no output is produced for the aborted operands.
- States: IDLE, SQR1, MUL1, SQR2, MUL2, SQR3, MUL3, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at edge N: r<=dividend, s<=divisor, latch zero flag (divisor==0), go to SQR1.
- SQRk: multiplier operands (s, s); s<=s*s; next MULk.
- MULk: multiplier operands (r, s); r<=r*s; next SQR(k+1), or HOLD after MUL3.
- Resulting values:
  - After MUL1: r=a*b^2. After MUL2: r=a*b^6. After MUL3: r=a*b^14 = a/b.
- Latency: out_valid goes high after edge N+6. quotient = r and div_by_zero = latched flag, both registered.
- in_ready=0 in every state except IDLE. No overlap of operations. Throughput: one division per 7 cycles plus the wait for out_ready.
- HOLD:
  - out_valid=1.
  - quotient and div_by_zero stable while out_ready=0. Indefinite backpressure is legal.
  - On out_valid && out_ready: out_valid<=0, return to IDLE; in_ready rises the cycle after acceptance.
  - Input cannot be accepted in the same cycle as output handoff.
- Divide by zero:
  - The datapath naturally yields quotient=0 (0^14=0).
  - div_by_zero=1 with the same timing.
  - The flag is cleared on the next acceptance.
- 0/b for b!=0: quotient=0, div_by_zero=0.
- Inputs dividend/divisor are ignored outside the IDLE acceptance edge. Changes during computation have no effect.
- The multiplier operand mux is driven from state only. Its combinational output is unused in IDLE/HOLD.
- Outside HOLD, quotient retains its last delivered value. Consumers qualify with out_valid.

Decomposition:
- Shared package ff_k4_pkg:
  - GF4_WIDTH=4
  - GF4_POLY=5'b10011
  - divider state enum (3-bit encoding)
  - GF4_EXP_INV=14
- Sub-module: reuse the existing FFMul_K4_Q2 (one instance, combinational). No new sub-module.
- FSM, operand mux and r/s registers are inline.

Test Plan:
- Reset then idle: hold rst high mid-cycle -> in_ready=1, out_valid=0, quotient=0 immediately (async); release -> accept a=12, b=3 -> out_valid exactly 6 edges later, quotient=4, div_by_zero=0.
- Known quotients, out_ready tied 1: 4/2 -> 2; 14/5 -> 8; 10/15 -> 15; 1/2 -> 9 (inverse of x). Each takes 7 cycles from acceptance to the next in_ready.
- Divide by zero: a=7, b=0 -> quotient=0, div_by_zero=1 at the same latency. Next op 12/4 -> quotient=3, div_by_zero=0.
- Backpressure: 12/3 with out_ready=0 for 10 cycles -> out_valid, quotient=4 stable throughout, in_ready=0. On out_ready=1 -> out_valid drops next edge, in_ready=1 the following cycle.
- Input isolation and abort:
  - Change divisor to 0 during MUL1 -> result is still from the original operands.
  - Assert rst during SQR2 -> out_valid never rises for that op; state is IDLE after release.
- Exhaustive round-trip: for all a, all b!=0: divide, then FFMul_K4_Q2(quotient, b) == a.
